// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_ctrl_pkg;

    localparam int unsigned LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        StPrst     = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } pll_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset (resets to 0).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock over a stability
// window, retries on timeout and releases the system reset only while lock holds.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 50,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 5000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  lock_ok,
    output logic                  fail,
    output logic [2:0]            state,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int unsigned TmrMax = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    pll_state_t             state_q, state_d;
    logic [TmrW-1:0]        tmr_q, tmr_d;
    logic [RetryW-1:0]      retry_q, retry_d;
    logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
    logic                   pll_rst_q, sys_rst_n_q, lock_ok_q, fail_q;
    logic                   lk;
    logic                   attempt_fail;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        retry_d      = retry_q;
        loss_d       = loss_q;
        attempt_fail = 1'b0;

        if (relock_req) begin
            state_d = StPrst;
            tmr_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StPrst: begin
                    if (tmr_q == TmrW'(RST_CYCLES - 1)) begin
                        tmr_d   = '0;
                        state_d = StWaitLock;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                StWaitLock: begin
                    if (lk) begin
                        tmr_d   = '0;
                        state_d = StStable;
                    end else if (tmr_q == TmrW'(LOCK_TIMEOUT - 1)) begin
                        attempt_fail = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                StStable: begin
                    if (!lk) begin
                        attempt_fail = 1'b1;
                    end else if (tmr_q == TmrW'(STABLE_CYCLES - 1)) begin
                        retry_d = '0;
                        state_d = StRun;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                StRun: begin
                    if (!lk) begin
                        if (loss_q != '1) begin
                            loss_d = loss_q + LOSS_CNT_W'(1);
                        end
                        tmr_d   = '0;
                        retry_d = '0;
                        state_d = StPrst;
                    end
                end
                StFail: begin
                end
                default: begin
                    tmr_d   = '0;
                    retry_d = '0;
                    state_d = StPrst;
                end
            endcase

            // A timed-out or unstable attempt either retries or gives up.
            if (attempt_fail) begin
                tmr_d = '0;
                if (retry_q == RetryW'(MAX_RETRIES - 1)) begin
                    state_d = StFail;
                end else begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = StPrst;
                end
            end
        end
    end

    // Outputs are registered decodes of the next state, so they never glitch.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPrst;
            tmr_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == StPrst) || (state_d == StFail);
            sys_rst_n_q <= (state_d == StRun);
            lock_ok_q   <= (state_d == StRun);
            fail_q      <= (state_d == StFail);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign lock_ok   = lock_ok_q;
    assign fail      = fail_q;
    assign state     = state_q;
    assign loss_cnt  = loss_q;

endmodule
